// File: rtl/companion_stat_driver.sv
// companion_stat_driver
//
// Control-side partner of the companion stat register. Produces the periodic
// decay pulse (tick) and the user refresh pulse (refresh) for one stat,
// debounces the user button, enforces a cooldown between refreshes and flags
// a low stat value.
//
// Refresh is only issued while the prescaler sits in [0, TICK_PERIOD-4], so
// the stat register's derived clock (tick OR refresh delayed by one cycle)
// always sees two separate rising edges.
//
// Optional feature macro: COMPANION_DRIVER_REQ_LATCH_EN
//   defined   : a button request arriving during COOLDOWN is remembered in a
//               one-deep latch and served right after the cooldown ends.
//   undefined : a request during COOLDOWN is dropped.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   btn       in   raw asynchronous button, active-high
//   value     in   [31:0] current stat value
//   tick      out  one-cycle decay pulse (cnt == TICK_PERIOD-1)
//   refresh   out  one-cycle refresh pulse (FSM in REFRESH)
//   cooldown  out  high while the FSM is in COOLDOWN
//   alert     out  registered (value < LOW_THRESHOLD)
//   fsm_state out  [1:0] debug view of the FSM state
//                  (0 IDLE, 1 PENDING, 2 REFRESH, 3 COOLDOWN)

module companion_stat_driver #(
  parameter int TICK_PERIOD     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_TICKS  = 3,
  parameter int LOW_THRESHOLD   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
  input  logic [31:0] value,
  output logic        tick,
  output logic        refresh,
  output logic        cooldown,
  output logic        alert,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    REFRESH  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [31:0] TP_LAST  = 32'(TICK_PERIOD - 1);
  // Last prescaler value at which refresh may be high.
  localparam logic [31:0] WIN_LAST = 32'(TICK_PERIOD - 4);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  localparam int CTW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [CTW-1:0] CT_LAST =
    CTW'((COOLDOWN_TICKS > 0) ? (COOLDOWN_TICKS - 1) : 0);

  // Prescaler
  logic [31:0] cnt;
  logic [31:0] cnt_next;

  assign cnt_next = (cnt == TP_LAST) ? 32'd0 : cnt + 32'd1;
  assign tick     = (cnt == TP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 32'd0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // Two-flop synchronizer
  logic sync1;
  logic btn_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
    end
  end

  // Debouncer: lvl flips after DEBOUNCE_CYCLES consecutive disagreeing
  // samples. The flip happens on the edge that completes the run, so the
  // counter only needs to reach DEBOUNCE_CYCLES-1.
  logic [DBW-1:0] db_cnt;
  logic           lvl;
  logic           lvl_q;
  logic           req;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      lvl    <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      lvl_q <= lvl;
      if (btn_s != lvl) begin
        if (db_cnt == DB_LAST) begin
          lvl    <= ~lvl;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Press only; the release edge of lvl is not a request.
  assign req = lvl & ~lvl_q;

  // FSM
  state_t         state_q;
  state_t         state_next;
  logic [CTW-1:0] tcnt;

`ifdef COMPANION_DRIVER_REQ_LATCH_EN
  logic req_latch;
  logic latch_hit;

  // A request in the very cycle the cooldown ends is served too.
  assign latch_hit = req_latch | req;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_latch <= 1'b0;
    end else if (state_q == COOLDOWN && state_next != COOLDOWN) begin
      req_latch <= 1'b0;
    end else if (state_q == COOLDOWN && req) begin
      req_latch <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Cooldown tick counter, cleared on the refresh cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state_q == REFRESH) begin
      tcnt <= '0;
    end else if (state_q == COOLDOWN && tick) begin
      tcnt <= tcnt + CTW'(1);
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        // Enter REFRESH only if the refresh cycle lands inside the window.
        if (cnt_next <= WIN_LAST) begin
          state_next = REFRESH;
        end
      end
      REFRESH: begin
        if (COOLDOWN_TICKS == 0) begin
          state_next = IDLE;
        end else begin
          state_next = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (tick && tcnt == CT_LAST) begin
`ifdef COMPANION_DRIVER_REQ_LATCH_EN
          state_next = latch_hit ? PENDING : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign refresh   = (state_q == REFRESH);
  assign cooldown  = (state_q == COOLDOWN);
  assign fsm_state = state_q;

  // Low-stat alert
  always_ff @(posedge clk) begin
    if (rst) begin
      alert <= 1'b0;
    end else begin
      alert <= (value < 32'(LOW_THRESHOLD));
    end
  end

endmodule

// File: tb/tb_companion_stat_driver.sv
// Testbench for companion_stat_driver.
// Cycle t = cycles since the last reset edge (t = 0 is the reset-state cycle).
// Inputs for cycle t are driven at its falling edge; outputs of cycle t are
// compared at the same falling edge against an event-level model.

module tb_companion_stat_driver;

  localparam int TP = 20;
  localparam int DB = 4;
  localparam int CT = 2;
  localparam int LT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn = 1'b0;
  logic [31:0] value = 32'd10;
  logic        tick;
  logic        refresh;
  logic        cooldown;
  logic        alert;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  companion_stat_driver #(
    .TICK_PERIOD    (TP),
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_TICKS (CT),
    .LOW_THRESHOLD  (LT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .value    (value),
    .tick     (tick),
    .refresh  (refresh),
    .cooldown (cooldown),
    .alert    (alert),
    .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   t;
  bit   prev_rst = 1'b1;
  bit   m_b1, m_b2;          // btn one and two cycles ago
  bit   m_lvl, m_lvl_prev;   // debounced level now / last cycle
  logic bs_q[$];             // synchronized samples since last level flip
  int   m_ref_t;             // scheduled refresh cycle, -1 if none
  int   m_last_ref;          // cycle of the last refresh
  int   m_cd_end;            // last cycle of that refresh's cooldown
  bit   m_latch;
  bit   m_alert;

  // Observations of the DUT since the last reset
  int ref_count, first_ref_t, last_ref_t, last_cd_t, tick_count;

  task automatic model_reset();
    t = 0;
    m_b1 = 0; m_b2 = 0;
    m_lvl = 0; m_lvl_prev = 0;
    bs_q.delete();
    m_ref_t = -1; m_last_ref = -1; m_cd_end = -1;
    m_latch = 0; m_alert = 0;
    ref_count = 0; first_ref_t = -1; last_ref_t = -1;
    last_cd_t = -1; tick_count = 0;
  endtask

  // First cycle >= s in which refresh may be high.
  function automatic int next_window(int s);
    int c = s;
    while ((c % TP) > TP - 4) c++;
    return c;
  endfunction

  task automatic run_cycle(input bit b, input logic [31:0] v, input bit r);
    bit bs, rq, e_tick, e_ref, in_cd, flip;
    @(negedge clk);
    if (prev_rst) model_reset();
    bs     = m_b2;
    rq     = m_lvl && !m_lvl_prev;
    e_tick = ((t % TP) == TP - 1);
    e_ref  = (t == m_ref_t);
    in_cd  = (m_last_ref >= 0) && (t > m_last_ref) && (t <= m_cd_end);

    checks++;
    if (tick !== e_tick) begin
      errors++;
      $display("FAIL tick t=%0d got=%b exp=%b", t, tick, e_tick);
    end
    checks++;
    if (refresh !== e_ref) begin
      errors++;
      $display("FAIL refresh t=%0d got=%b exp=%b", t, refresh, e_ref);
    end
    checks++;
    if (cooldown !== in_cd) begin
      errors++;
      $display("FAIL cooldown t=%0d got=%b exp=%b", t, cooldown, in_cd);
    end
    checks++;
    if (alert !== m_alert) begin
      errors++;
      $display("FAIL alert t=%0d got=%b exp=%b", t, alert, m_alert);
    end

    if (refresh === 1'b1) begin
      ref_count++;
      if (first_ref_t < 0) first_ref_t = t;
      last_ref_t = t;
    end
    if (cooldown === 1'b1) last_cd_t = t;
    if (tick === 1'b1) tick_count++;

    // Request scheduling: served from IDLE only.
    if (rq && m_ref_t < 0) begin
      if (!in_cd) m_ref_t = next_window(t + 2);
`ifdef COMPANION_DRIVER_REQ_LATCH_EN
      else m_latch = 1'b1;
`endif
    end
    if (e_ref) begin
      m_last_ref = t;
      if (CT == 0) m_cd_end = t;
      else m_cd_end = t + (TP - 1 - (t % TP)) + (CT - 1) * TP;
      m_ref_t = -1;
    end
`ifdef COMPANION_DRIVER_REQ_LATCH_EN
    if (in_cd && t == m_cd_end && m_latch) begin
      m_ref_t = next_window(t + 2);
      m_latch = 1'b0;
    end
`endif

    // Debounce: flip after DB consecutive samples disagreeing with the level.
    bs_q.push_back(bs);
    if (bs_q.size() > DB) void'(bs_q.pop_front());
    flip = (bs_q.size() == DB);
    foreach (bs_q[i]) if (bs_q[i] == m_lvl) flip = 1'b0;
    m_lvl_prev = m_lvl;
    if (flip) begin
      m_lvl = !m_lvl;
      bs_q.delete();
    end
    m_b2 = m_b1;
    m_b1 = b;
    m_alert = (v < LT);

    btn = b; value = v; rst = r;
    prev_rst = r;
    t++;
  endtask

  task automatic do_reset();
    run_cycle(1'b0, 32'd10, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 32'd1, 1'b1);
      checks++;
      if ({tick, refresh, cooldown, alert} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs got=%b exp=0000", {tick, refresh, cooldown, alert});
      end
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 100; i++) run_cycle(1'b0, 32'd10, 1'b0);
    checks++;
    if (tick_count != 5) begin
      errors++; $display("FAIL idle_ticks got=%0d exp=5", tick_count);
    end
    checks++;
    if (ref_count != 0 || last_cd_t != -1) begin
      errors++; $display("FAIL idle_quiet refreshes=%0d last_cd=%0d exp=0/-1", ref_count, last_cd_t);
    end
  endtask

  task automatic test_press();
    do_reset();
    for (int i = 0; i < 60; i++) run_cycle(i >= 3, 32'd10, 1'b0);
    checks++;
    if (ref_count != 1 || first_ref_t != 11) begin
      errors++; $display("FAIL press_refresh count=%0d at=%0d exp=1 at 11", ref_count, first_ref_t);
    end
    checks++;
    if (last_cd_t != 39) begin
      errors++; $display("FAIL press_cooldown_end got=%0d exp=39", last_cd_t);
    end
  endtask

  task automatic test_window();
    do_reset();
    for (int i = 0; i < 70; i++) run_cycle(i >= 9 && i < 30, 32'd10, 1'b0);
    checks++;
    if (ref_count != 1 || first_ref_t != 20) begin
      errors++; $display("FAIL window_refresh count=%0d at=%0d exp=1 at 20", ref_count, first_ref_t);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 40; i++) run_cycle(i >= 5 && i < 8, 32'd10, 1'b0);
    checks++;
    if (ref_count != 0) begin
      errors++; $display("FAIL glitch_no_refresh got=%0d exp=0", ref_count);
    end
    for (int i = 0; i < 60; i++) run_cycle(i >= 2 && i < 6, 32'd10, 1'b0);
    checks++;
    if (ref_count != 1 || first_ref_t != 50) begin
      errors++; $display("FAIL stable_pulse count=%0d at=%0d exp=1 at 50", ref_count, first_ref_t);
    end
  endtask

  task automatic test_cooldown_press();
    do_reset();
    for (int i = 0; i < 90; i++)
      run_cycle((i >= 3 && i < 16) || (i >= 25 && i < 35), 32'd10, 1'b0);
`ifdef COMPANION_DRIVER_REQ_LATCH_EN
    checks++;
    if (ref_count != 2 || last_ref_t != 41 || last_cd_t != 79) begin
      errors++;
      $display("FAIL cooldown_press count=%0d last=%0d cd_end=%0d exp=2/41/79", ref_count, last_ref_t, last_cd_t);
    end
`else
    checks++;
    if (ref_count != 1 || last_cd_t != 39) begin
      errors++;
      $display("FAIL cooldown_press count=%0d cd_end=%0d exp=1/39", ref_count, last_cd_t);
    end
`endif
  endtask

  task automatic test_alert();
    int vals[5] = '{4, 3, 2, 0, 10};
    bit exp_a[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_cycle(1'b0, vals[k], 1'b0);
      if (k > 0) begin
        checks++;
        if (alert !== exp_a[k-1]) begin
          errors++; $display("FAIL alert_step%0d got=%b exp=%b", k - 1, alert, exp_a[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    for (int i = 0; i < 17; i++) run_cycle(i >= 9 && i < 16, 32'd1, 1'b0);
    checks++;
    if (fsm_state !== 2'd1) begin
      errors++; $display("FAIL pending_before_reset state=%0d exp=1", fsm_state);
    end
    run_cycle(1'b0, 32'd1, 1'b1);
    run_cycle(1'b0, 32'd10, 1'b0);
    checks++;
    if ({tick, refresh, cooldown, alert} !== 4'b0000) begin
      errors++; $display("FAIL reset_pending_outputs got=%b exp=0000", {tick, refresh, cooldown, alert});
    end
    for (int i = 0; i < 60; i++) run_cycle(1'b0, 32'd10, 1'b0);
    checks++;
    if (ref_count != 0 || tick_count != 3) begin
      errors++; $display("FAIL reset_pending_after refreshes=%0d ticks=%0d exp=0/3", ref_count, tick_count);
    end
  endtask

  task automatic test_random();
    bit lvl_r = 1'b0;
    do_reset();
    for (int seg = 0; seg < 300; seg++) begin
      int hold = $urandom_range(1, 14);
      lvl_r = ~lvl_r;
      for (int i = 0; i < hold; i++)
        run_cycle(lvl_r, 32'($urandom_range(0, 6)), ($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 80; i++) run_cycle(1'b0, 32'd5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press();
    test_window();
    test_glitch();
    test_cooldown_press();
    test_alert();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
